reg_bank_arbiter: RTL
=====================

Name: reg_bank_arbiter

Overview:
Shares the 12-bit instruction port of the two-register bank (opcodes NOP=4'h0, LD0=4'h1, LD1=4'h2, imm in [7:0]) between two requesters. Round-robin arbitration, valid/ready handshake per requester, registered single-stream output (inst/inst_en) driving the bank directly. Screens opcodes: an illegal opcode is consumed, not forwarded, and latches a sticky error, matching the bank's Reset/Ready/Error state philosophy.

Parameters:
CNT_W, 8, width of forwarded-instruction counter (wraps).

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled on clock rising edge; reset==0 resets)
req0_inst  in  12  requester 0 instruction {code[3:0], imm[7:0]}
req0_valid  in  1  requester 0 instruction valid
req0_ready  out  1  requester 0 accepted this cycle (combinational)
req1_inst  in  12  requester 1 instruction
req1_valid  in  1  requester 1 instruction valid
req1_ready  out  1  requester 1 accepted this cycle (combinational)
inst  out  12  instruction to bank (registered)
inst_en  out  1  instruction valid to bank (registered)
last_grant  out  1  index of requester that won most recent transfer
error  out  1  sticky illegal-opcode flag
fwd_count  out  CNT_W  number of instructions forwarded, mod 2^CNT_W

Behaviour:
- States: Reset(2'h0), Ready(2'h1), Error(2'h2); 2'h3 unreachable, treated as Error.
- reset==0 at an edge: state<=Reset, inst<=0, inst_en<=0, last_grant<=1 (req0 wins first tie), error<=0, fwd_count<=0. Overrides everything, including mid-transfer.
- Reset: one cycle, req*_ready=0, inst_en<=0, next state Ready.
- Ready, arbitration (combinational from current inputs):
  - only reqN_valid=1 -> winner N.
  - both valid -> winner = ~last_grant (round-robin alternation).
  - none valid -> no winner; all ready=0.
  - reqN_ready=1 only for the winner; ready never depends on ready of the other port.
- Transfer = winner valid & ready. On transfer, at the edge:
  - last_grant<=winner.
  - code in {0,1,2}: inst<=winner inst, inst_en<=1, fwd_count<=fwd_count+1 (wrap 2^CNT_W-1 -> 0). Latency: accept in cycle T -> inst_en=1 in cycle T+1.
  - code >= 3: instruction consumed (ready was 1), inst<=0, inst_en<=0, error<=1, state<=Error. Not forwarded.
- Ready, no transfer: inst<=0, inst_en<=0; counters, last_grant hold.
- Error: all ready=0, inst_en=0, inst=0, error=1; held until reset. Requesters see permanent back-pressure.
- Back-to-back: one transfer per cycle max; sustained dual valid alternates 0,1,0,1...; single requester may transfer every cycle.
- NOP is forwarded (counts) exactly like LD0/LD1.
- Outputs inst/inst_en/error/fwd_count/last_grant all registered; only req*_ready are combinational.

Decomposition:
- Shared package/header: opcode constants (NOP/LD0/LD1), state encodings (Reset/Ready/Error), instruction field slices (code [11:8], imm [7:0]) — reused by the bank and this arbiter.
- One sub-module natural: rr_arb2 (combinational 2-way round-robin winner/ready given valids and last_grant). Remaining FSM, output registers, counter in top.

Test Plan:
- Reset release: reset=0 two cycles then 1 -> cycle 1 after release all ready=0; from cycle 2 req0_valid=1 with 12'h1A5 -> req0_ready=1, next cycle inst=12'h1A5, inst_en=1, fwd_count=1.
- Contention: both valid continuously, req0=12'h111, req1=12'h222, 4 cycles -> grants 0,1,0,1; inst stream 111,222,111,222 each one cycle after accept; fwd_count=4.
- Single requester streaming: req1_valid=1 for 3 cycles with 12'h2FF, 12'h000, 12'h210 -> 3 back-to-back inst_en pulses, values in order, last_grant=1.
- Illegal opcode: req0 sends 12'h3C4 -> req0_ready=1 that cycle, next cycle error=1, inst_en=0; subsequent req1 12'h101 never accepted (ready stays 0) until reset.
- Counter wrap: forward 256 NOPs (CNT_W=8) -> fwd_count returns to 0, inst_en pulses 256 times, error stays 0.
- Reset mid-stream: both valid streaming, reset=0 for one cycle -> next cycle inst_en=0, fwd_count=0, last_grant=1, error=0; after Reset cycle req0 wins first tie.

Source files
------------

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the two-register bank instruction port:
// opcodes, controller state encodings and instruction field helpers.
package reg_bank_arbiter_pkg;

  localparam int INST_W = 12;
  localparam int CODE_W = 4;
  localparam int IMM_W  = 8;

  localparam logic [CODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [CODE_W-1:0] OP_LD0 = 4'h1;
  localparam logic [CODE_W-1:0] OP_LD1 = 4'h2;

  typedef enum logic [1:0] {
    ST_RESET = 2'h0,
    ST_READY = 2'h1,
    ST_ERROR = 2'h2
  } state_t;

  function automatic logic [CODE_W-1:0] inst_code(input logic [INST_W-1:0] inst);
    return inst[INST_W-1:IMM_W];
  endfunction

  function automatic logic [IMM_W-1:0] inst_imm(input logic [INST_W-1:0] inst);
    return inst[IMM_W-1:0];
  endfunction

  // Only NOP/LD0/LD1 are understood by the bank; everything above is illegal.
  function automatic logic is_legal(input logic [CODE_W-1:0] code);
    return (code == OP_NOP) || (code == OP_LD0) || (code == OP_LD1);
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Bundles both requester handshakes and the bank-side instruction stream.
interface reg_bank_arbiter_if #(
  parameter int CNT_W = 8
);
  import reg_bank_arbiter_pkg::*;

  logic [INST_W-1:0] req0_inst;
  logic              req0_valid;
  logic              req0_ready;
  logic [INST_W-1:0] req1_inst;
  logic              req1_valid;
  logic              req1_ready;
  logic [INST_W-1:0] inst;
  logic              inst_en;
  logic              last_grant;
  logic              error;
  logic [CNT_W-1:0]  fwd_count;

  modport master (
    output req0_inst, req0_valid, req1_inst, req1_valid,
    input  req0_ready, req1_ready, inst, inst_en, last_grant, error, fwd_count
  );

  modport slave (
    input  req0_inst, req0_valid, req1_inst, req1_valid,
    output req0_ready, req1_ready, inst, inst_en, last_grant, error, fwd_count
  );

endinterface

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// Combinational two-way round-robin arbiter: picks a winner from the current
// valids and the previous winner; ready goes only to the winner.
module reg_bank_arbiter_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic enable,
  output logic ready0,
  output logic ready1,
  output logic grant,
  output logic winner
);

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    winner = 1'b0;
    if (valid0 && valid1) begin
      winner = ~last_grant;
    end else if (valid1) begin
      winner = 1'b1;
    end
  end

  assign grant  = enable & (valid0 | valid1);
  assign ready0 = grant & ~winner;
  assign ready1 = grant &  winner;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares the bank instruction port between two requesters, forwards legal
// opcodes one cycle after acceptance and halts on the first illegal one.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  reg_bank_arbiter_if.slave   bus
);

  state_t            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_en_q, inst_en_d;
  logic              last_grant_q, last_grant_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  fwd_count_q, fwd_count_d;

  logic              ready0, ready1, grant, winner;
  logic [INST_W-1:0] win_inst;

  reg_bank_arbiter_rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .enable     (state_q == ST_READY),
    .ready0     (ready0),
    .ready1     (ready1),
    .grant      (grant),
    .winner     (winner)
  );

  assign win_inst = winner ? bus.req1_inst : bus.req0_inst;

  // Next state and registered outputs; every cycle without a legal transfer
  // drives an empty instruction to the bank.
  always_comb begin
    state_d      = state_q;
    inst_d       = '0;
    inst_en_d    = 1'b0;
    last_grant_d = last_grant_q;
    error_d      = error_q;
    fwd_count_d  = fwd_count_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_READY;
      end
      ST_READY: begin
        if (grant) begin
          last_grant_d = winner;
          if (is_legal(inst_code(win_inst))) begin
            inst_d      = win_inst;
            inst_en_d   = 1'b1;
            fwd_count_d = fwd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      default: begin
        // Error, and the unused encoding, hold until reset.
        state_d = ST_ERROR;
        error_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      inst_q       <= '0;
      inst_en_q    <= 1'b0;
      last_grant_q <= 1'b1;
      error_q      <= 1'b0;
      fwd_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_en_q    <= inst_en_d;
      last_grant_q <= last_grant_d;
      error_q      <= error_d;
      fwd_count_q  <= fwd_count_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.inst       = inst_q;
  assign bus.inst_en    = inst_en_q;
  assign bus.last_grant = last_grant_q;
  assign bus.error      = error_q;
  assign bus.fwd_count  = fwd_count_q;

endmodule
